// File: rtl/div_seq_pkg.sv
// Shared CPU constants used by the HI/LO producers (divider and multiplier).
package div_seq_pkg;

  // Divider FSM encodings
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

  // HI/LO source-mux selects, shared with the mult unit
  localparam logic [1:0] HILO_SEL_REG  = 2'd0;
  localparam logic [1:0] HILO_SEL_MULT = 2'd1;
  localparam logic [1:0] HILO_SEL_DIV  = 2'd2;

endpackage

// File: rtl/div_seq.sv
// Sequential signed restoring divider: quotient -> lo, remainder -> hi.
// One quotient bit per cycle, then a sign-fixup cycle, then a one-cycle done.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  div_state_t       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dsr;
  logic             q_neg, r_neg;
  logic [WIDTH:0]   rs, trial;

  // Partial remainder shifted left by one with the next dividend bit, and the
  // trial subtraction; the top bit of trial is the borrow (trial < 0).
  assign rs    = {rem, quo[WIDTH-1]};
  assign trial = rs - {1'b0, dsr};

  assign busy = (state == DIV_CALC) || (state == DIV_FIX);
  assign done = (state == DIV_DONE);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a zero divisor never leaves IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      DIV_IDLE: if (start && (divisor != '0)) state_nxt = DIV_CALC;
      DIV_CALC: if (cnt == CW'(1))            state_nxt = DIV_FIX;
      DIV_FIX:                                state_nxt = DIV_DONE;
      DIV_DONE:                               state_nxt = DIV_IDLE;
      default:                                state_nxt = DIV_IDLE;
    endcase
  end

  // Operand capture, iteration datapath, sign fixup and result registers.
  // Magnitudes are unsigned, so |0x80000000| = 0x80000000 is exact.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dsr      <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      div_zero <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              div_zero <= 1'b1;
            end else begin
              quo   <= dividend[WIDTH-1] ? -dividend : dividend;
              dsr   <= divisor[WIDTH-1]  ? -divisor  : divisor;
              rem   <= '0;
              q_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              r_neg <= dividend[WIDTH-1];
              cnt   <= CW'(WIDTH);
            end
          end
        end
        DIV_CALC: begin
          cnt <= cnt - CW'(1);
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rs[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
        end
        DIV_FIX: begin
          lo <= q_neg ? -quo : quo;
          hi <= r_neg ? -rem : rem;
        end
        default: ;
      endcase
    end
  end

endmodule
